// File: rtl/fifo_frame_reader_pkg.sv
// Shared types and helpers for the FIFO frame reader: FSM states, header
// field positions and a saturating increment for the status counters.
package fifo_frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } frame_state_e;

  localparam int HDR_LEN_LSB  = 0;
  localparam int HDR_LEN_MSB  = 15;
  localparam int HDR_DEST_LSB = 16;
  localparam int HDR_DEST_MSB = 23;

  // Counters up to 32 bits wide share this helper; callers cast to width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_frame_reader_frame_out_reg.sv
// Single-stage valid/ready output register carrying payload data and the
// sop/eop/err frame flags.
module frame_out_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  input  logic                  in_err,
  input  logic                  m_ready,
  output logic                  slot_free,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic                  m_err
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic                  err_q, err_d;

  // Handshake: a word transfers on a rising edge where m_valid && m_ready;
  // once m_valid rises, data and flags hold until that transfer.
  assign slot_free = !valid_q || m_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    err_d   = err_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_data;
      sop_d   = in_sop;
      eop_d   = in_eop;
      err_d   = in_err;
    end else if (m_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      err_q   <= err_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_sop   = sop_q;
  assign m_eop   = eop_q;
  assign m_err   = err_q;

endmodule

// File: rtl/fifo_frame_reader.sv
// Read-side frame parser for a FWFT FIFO: strips a one-word header, streams
// the payload with sop/eop/err/dest, drops malformed frames, counts frames.
module fifo_frame_reader
  import fifo_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LEN    = 1024,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH:0]   fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic                  m_err,
  output logic [7:0]            m_dest,
  output logic [CNT_WIDTH-1:0]  frm_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam int          REM_W   = $clog2(MAX_LEN + 1);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_WIDTH) - 64'd1);

  frame_state_e          state_q, state_d;
  logic [REM_W-1:0]      rem_q, rem_d;
  logic                  first_q, first_d;
  logic [7:0]            dest_q, dest_d;
  logic [CNT_WIDTH-1:0]  frm_cnt_q, frm_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

  logic                  rd_en;
  logic                  slot_free;
  logic                  ld;
  logic                  ld_eop;
  logic                  ld_err;

  logic                  word_eop;
  logic [DATA_WIDTH-1:0] word_data;
  logic [15:0]           hdr_len;
  logic [7:0]            hdr_dest;
  logic                  hdr_len_bad;

  assign word_eop    = fifo_dout[DATA_WIDTH];
  assign word_data   = fifo_dout[DATA_WIDTH-1:0];
  assign hdr_len     = word_data[HDR_LEN_MSB:HDR_LEN_LSB];
  assign hdr_dest    = word_data[HDR_DEST_MSB:HDR_DEST_LSB];
  assign hdr_len_bad = (hdr_len == 16'd0) || ({16'd0, hdr_len} > 32'(MAX_LEN));

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    first_d   = first_q;
    dest_d    = dest_q;
    frm_cnt_d = frm_cnt_q;
    err_cnt_d = err_cnt_q;
    rd_en     = 1'b0;
    ld        = 1'b0;
    ld_eop    = 1'b0;
    ld_err    = 1'b0;
    case (state_q)
      IDLE: begin
        rd_en = !fifo_empty;
        if (rd_en) begin
          // A header carrying eop is a complete (empty) frame, so no DROP.
          if (word_eop) begin
            err_cnt_d = CNT_WIDTH'(sat_inc(32'(err_cnt_q), CNT_MAX));
          end else if (hdr_len_bad) begin
            err_cnt_d = CNT_WIDTH'(sat_inc(32'(err_cnt_q), CNT_MAX));
            state_d   = DROP;
          end else begin
            rem_d   = hdr_len[REM_W-1:0];
            dest_d  = hdr_dest;
            first_d = 1'b1;
            state_d = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        rd_en = !fifo_empty && slot_free;
        if (rd_en) begin
          ld      = 1'b1;
          first_d = 1'b0;
          rem_d   = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1)) begin
            ld_eop = 1'b1;
            if (word_eop) begin
              frm_cnt_d = CNT_WIDTH'(sat_inc(32'(frm_cnt_q), CNT_MAX));
              state_d   = IDLE;
            end else begin
              ld_err    = 1'b1;
              err_cnt_d = CNT_WIDTH'(sat_inc(32'(err_cnt_q), CNT_MAX));
              state_d   = DROP;
            end
          end else if (word_eop) begin
            ld_eop    = 1'b1;
            ld_err    = 1'b1;
            err_cnt_d = CNT_WIDTH'(sat_inc(32'(err_cnt_q), CNT_MAX));
            state_d   = IDLE;
          end
        end
      end
      DROP: begin
        rd_en = !fifo_empty;
        if (rd_en && word_eop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      first_q   <= 1'b0;
      dest_q    <= '0;
      frm_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      first_q   <= first_d;
      dest_q    <= dest_d;
      frm_cnt_q <= frm_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  frame_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .in_data  (word_data),
    .in_sop   (first_q),
    .in_eop   (ld_eop),
    .in_err   (ld_err),
    .m_ready  (m_ready),
    .slot_free(slot_free),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_sop    (m_sop),
    .m_eop    (m_eop),
    .m_err    (m_err)
  );

  assign fifo_rd_en = rd_en;
  assign m_dest     = dest_q;
  assign frm_cnt    = frm_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader: a queue-backed FWFT FIFO model feeds
// frames; accepted output beats are logged and checked against fixed values.
module tb_fifo_frame_reader;

  localparam int DW = 32;
  localparam int ML = 1024;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW:0]   fifo_dout;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_sop;
  logic          m_eop;
  logic          m_err;
  logic [7:0]    m_dest;
  logic [CW-1:0] frm_cnt;
  logic [CW-1:0] err_cnt;

  fifo_frame_reader #(.DATA_WIDTH(DW), .MAX_LEN(ML), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_sop     (m_sop),
    .m_eop     (m_eop),
    .m_err     (m_err),
    .m_dest    (m_dest),
    .frm_cnt   (frm_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int            tests = 0;
  int            fails = 0;
  logic [DW:0]   fq[$];
  logic [DW-1:0] acc_d[$];
  logic [2:0]    acc_f[$];
  logic          force_empty;
  int            rd_viol;
  int            valid_seen;
  logic          s_valid;
  logic          s_rd;
  logic [DW-1:0] s_data;

  localparam logic [DW-1:0] A = 32'hAAAA_0001, B = 32'hBBBB_0002, C = 32'hCCCC_0003;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW:0] hdr(input logic [15:0] len, input logic [7:0] dest,
                                      input logic eop);
    return {eop, 8'hC3, dest, len};
  endfunction

  function automatic logic [DW:0] wrd(input logic [DW-1:0] d, input logic eop);
    return {eop, d};
  endfunction

  // Present FIFO state at the falling edge, sample, then pop on the rising edge.
  task automatic cyc();
    fifo_empty = force_empty || (fq.size() == 0);
    fifo_dout  = (fq.size() != 0) ? fq[0] : '0;
    #1;
    s_valid = m_valid;
    s_data  = m_data;
    s_rd    = fifo_rd_en;
    if (fifo_empty && fifo_rd_en) rd_viol++;
    if (m_valid) valid_seen++;
    if (m_valid && m_ready) begin
      acc_d.push_back(m_data);
      acc_f.push_back({m_sop, m_eop, m_err});
    end
    @(posedge clk);
    if (s_rd && fq.size() != 0) fq.delete(0);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((fq.size() != 0 || m_valid) && n < 300) begin
      cyc();
      n++;
    end
    repeat (2) cyc();
    chk({tag, "_drain_done"}, 64'(n < 300), 64'd1);
  endtask

  task automatic chk_beat(input string tag, input int i, input logic [DW-1:0] d,
                          input logic [2:0] f);
    chk({tag, "_data"}, (i < acc_d.size()) ? 64'(acc_d[i]) : 64'hDEAD, 64'(d));
    chk({tag, "_sop_eop_err"}, (i < acc_f.size()) ? 64'(acc_f[i]) : 64'hDEAD, 64'(f));
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    force_empty = 1'b1;
    fifo_empty  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n       = 1'b1;
    force_empty = 1'b0;
    m_ready     = 1'b1;
    fq.delete();
    acc_d.delete();
    acc_f.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n       = 1'b0;
    m_ready     = 1'b1;
    force_empty = 1'b1;
    fifo_empty  = 1'b1;
    fifo_dout   = '0;
    rd_viol     = 0;
    valid_seen  = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_frm_cnt", 64'(frm_cnt), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_m_dest", 64'(m_dest), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    force_empty = 1'b0;

    // Good frame, LEN=3 dest=0x5A, with first-word latency check.
    fq.push_back(hdr(16'd3, 8'h5A, 1'b0));
    fq.push_back(wrd(A, 1'b0));
    fq.push_back(wrd(B, 1'b0));
    fq.push_back(wrd(C, 1'b1));
    cyc();
    cyc();
    chk("good_lat_a_visible_no_valid", 64'(s_valid), 64'd0);
    cyc();
    chk("good_lat_first_valid", 64'(s_valid), 64'd1);
    chk("good_lat_first_data", 64'(s_data), 64'(A));
    drain("good");
    chk("good_beats", 64'(acc_d.size()), 64'd3);
    chk_beat("good_w0", 0, A, 3'b100);
    chk_beat("good_w1", 1, B, 3'b000);
    chk_beat("good_w2", 2, C, 3'b010);
    chk("good_dest", 64'(m_dest), 64'h5A);
    chk("good_frm_cnt", 64'(frm_cnt), 64'd1);
    chk("good_err_cnt", 64'(err_cnt), 64'd0);

    // Same frame with a 4-cycle stall on word B.
    acc_d.delete();
    acc_f.delete();
    fq.push_back(hdr(16'd3, 8'h5A, 1'b0));
    fq.push_back(wrd(A, 1'b0));
    fq.push_back(wrd(B, 1'b0));
    fq.push_back(wrd(C, 1'b1));
    repeat (3) cyc();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("bp_stall%0d_valid_rd_data", i), {31'd0, s_valid, s_rd, s_data},
          {31'd0, 1'b1, 1'b0, B});
    end
    m_ready = 1'b1;
    drain("bp");
    chk("bp_beats", 64'(acc_d.size()), 64'd3);
    chk_beat("bp_w0", 0, A, 3'b100);
    chk_beat("bp_w1", 1, B, 3'b000);
    chk_beat("bp_w2", 2, C, 3'b010);
    chk("bp_frm_cnt", 64'(frm_cnt), 64'd2);

    // Short frame LEN=4 ending on word 2, then a good LEN=1 frame.
    do_reset();
    fq.push_back(hdr(16'd4, 8'h11, 1'b0));
    fq.push_back(wrd(32'h0000_0101, 1'b0));
    fq.push_back(wrd(32'h0000_0102, 1'b1));
    fq.push_back(hdr(16'd1, 8'h22, 1'b0));
    fq.push_back(wrd(32'h0000_0201, 1'b1));
    drain("short");
    chk("short_beats", 64'(acc_d.size()), 64'd3);
    chk_beat("short_w0", 0, 32'h0000_0101, 3'b100);
    chk_beat("short_w1", 1, 32'h0000_0102, 3'b011);
    chk_beat("short_next", 2, 32'h0000_0201, 3'b110);
    chk("short_err_cnt", 64'(err_cnt), 64'd1);
    chk("short_frm_cnt", 64'(frm_cnt), 64'd1);
    chk("short_dest", 64'(m_dest), 64'h22);

    // Long frame LEN=2 with 4 words; tail dropped, then a good frame.
    do_reset();
    fq.push_back(hdr(16'd2, 8'h33, 1'b0));
    fq.push_back(wrd(32'h0000_0301, 1'b0));
    fq.push_back(wrd(32'h0000_0302, 1'b0));
    fq.push_back(wrd(32'h0000_0303, 1'b0));
    fq.push_back(wrd(32'h0000_0304, 1'b1));
    fq.push_back(hdr(16'd1, 8'h44, 1'b0));
    fq.push_back(wrd(32'h0000_0401, 1'b1));
    drain("long");
    chk("long_beats", 64'(acc_d.size()), 64'd3);
    chk_beat("long_w0", 0, 32'h0000_0301, 3'b100);
    chk_beat("long_w1", 1, 32'h0000_0302, 3'b011);
    chk_beat("long_next", 2, 32'h0000_0401, 3'b110);
    chk("long_err_cnt", 64'(err_cnt), 64'd1);
    chk("long_frm_cnt", 64'(frm_cnt), 64'd1);

    // Bad headers: LEN=0, LEN=MAX_LEN+1, then header carrying eop.
    do_reset();
    valid_seen = 0;
    fq.push_back(hdr(16'd0, 8'h55, 1'b0));
    fq.push_back(wrd(32'h0000_0501, 1'b0));
    fq.push_back(wrd(32'h0000_0502, 1'b1));
    drain("len0");
    chk("len0_no_valid", 64'(valid_seen), 64'd0);
    chk("len0_err_cnt", 64'(err_cnt), 64'd1);
    fq.push_back(hdr(16'(ML + 1), 8'h55, 1'b0));
    fq.push_back(wrd(32'h0000_0601, 1'b0));
    fq.push_back(wrd(32'h0000_0602, 1'b1));
    drain("lenmax1");
    chk("lenmax1_no_valid", 64'(valid_seen), 64'd0);
    chk("lenmax1_err_cnt", 64'(err_cnt), 64'd2);
    chk("lenmax1_frm_cnt", 64'(frm_cnt), 64'd0);
    fq.push_back(hdr(16'd2, 8'h66, 1'b1));
    fq.push_back(hdr(16'd1, 8'h77, 1'b0));
    fq.push_back(wrd(32'h0000_0701, 1'b1));
    drain("hdreop");
    chk("hdreop_beats", 64'(acc_d.size()), 64'd1);
    chk_beat("hdreop_w0", 0, 32'h0000_0701, 3'b110);
    chk("hdreop_err_cnt", 64'(err_cnt), 64'd3);
    chk("hdreop_frm_cnt", 64'(frm_cnt), 64'd1);
    chk("hdreop_dest", 64'(m_dest), 64'h77);

    // Reset while a payload word is held under backpressure.
    fq.push_back(hdr(16'd3, 8'h88, 1'b0));
    fq.push_back(wrd(32'h0000_0801, 1'b0));
    fq.push_back(wrd(32'h0000_0802, 1'b0));
    m_ready = 1'b0;
    repeat (3) cyc();
    chk("midrst_pre_valid", 64'(s_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_frm_cnt", 64'(frm_cnt), 64'd0);
    chk("midrst_err_cnt", 64'(err_cnt), 64'd0);
    chk("midrst_dest", 64'(m_dest), 64'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    force_empty = 1'b1;
    m_ready     = 1'b1;
    repeat (10) cyc();
    chk("empty_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("empty_no_valid", 64'(m_valid), 64'd0);
    force_empty = 1'b0;
    fq.delete();
    acc_d.delete();
    acc_f.delete();
    fq.push_back(hdr(16'd1, 8'h99, 1'b0));
    fq.push_back(wrd(32'h0000_0901, 1'b1));
    drain("resync");
    chk("resync_beats", 64'(acc_d.size()), 64'd1);
    chk_beat("resync_w0", 0, 32'h0000_0901, 3'b110);
    chk("resync_frm_cnt", 64'(frm_cnt), 64'd1);
    chk("rd_en_never_when_empty", 64'(rd_viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
